// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-boundary registers: occupancy
// encoding, per-boundary bundle widths and EX/MEM field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  // Per-boundary bundle widths
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 170;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 133;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 101;

  // EX/MEM control field offsets and widths (bit 7 is spare)
  localparam int EXMEM_MEMREAD_OFS  = 0;
  localparam int EXMEM_MEMWRITE_OFS = 1;
  localparam int EXMEM_REGWRITE_OFS = 2;
  localparam int EXMEM_BYTESEL_OFS  = 3;
  localparam int EXMEM_BYTESEL_W    = 2;
  localparam int EXMEM_MEMTOREG_OFS = 5;
  localparam int EXMEM_L16B_OFS     = 6;

  // EX/MEM data field offsets and widths
  localparam int EXMEM_ALURESULT_OFS   = 0;
  localparam int EXMEM_ALURESULT_W     = 32;
  localparam int EXMEM_INSTRUCTION_OFS = 32;
  localparam int EXMEM_INSTRUCTION_W   = 32;
  localparam int EXMEM_PC_OFS          = 64;
  localparam int EXMEM_PC_W            = 32;
  localparam int EXMEM_WRITEDATA_OFS   = 96;
  localparam int EXMEM_WRITEDATA_W     = 32;
  localparam int EXMEM_REGDEST_OFS     = 128;
  localparam int EXMEM_REGDEST_W       = 5;

  function automatic logic [1:0] occ_count(input occ_state_t s);
    return logic'(1'b0) ? 2'd0 : 2'(s);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous
// active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  output logic [CNT_W-1:0] Count
);

  logic [CNT_W-1:0] count_reg = '0;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (Enable && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign Count = count_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-boundary register: 2-entry skid buffer with registered
// In_Ready, flush, and a downstream-starvation counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Bubble_Count
);

  // Declaration initialisers give the same power-up image as reset
  occ_state_t        state_reg     = ST_EMPTY;
  occ_state_t        state_next;
  logic              in_ready_reg  = 1'b0;
  logic              in_ready_next;
  logic              out_valid_reg = 1'b0;
  logic              out_valid_next;
  logic [CTRL_W-1:0] main_ctrl_reg = '0;
  logic [CTRL_W-1:0] main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg = '0;
  logic [DATA_W-1:0] main_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg = '0;
  logic [CTRL_W-1:0] skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg = '0;
  logic [DATA_W-1:0] skid_data_next;

  logic push;
  logic pop;

  assign push = In_Valid & in_ready_reg;
  assign pop  = out_valid_reg & Out_Ready;

  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;

    case (state_reg)
      ST_EMPTY: begin
        if (push) begin
          state_next     = ST_ONE;
          main_ctrl_next = In_Ctrl;
          main_data_next = In_Data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_ctrl_next = In_Ctrl;
          main_data_next = In_Data;
        end else if (push) begin
          state_next     = ST_FULL;
          skid_ctrl_next = In_Ctrl;
          skid_data_next = In_Data;
        end else if (pop) begin
          // Head data is left in place so Out_Data holds its last value
          state_next     = ST_EMPTY;
          main_ctrl_next = '0;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_next     = ST_ONE;
          main_ctrl_next = skid_ctrl_reg;
          main_data_next = skid_data_reg;
          skid_ctrl_next = '0;
        end
      end
      default: begin
        state_next     = ST_EMPTY;
        main_ctrl_next = '0;
        main_data_next = '0;
        skid_ctrl_next = '0;
        skid_data_next = '0;
      end
    endcase

    // Flush overrides whatever the handshake decided this cycle
    if (Flush) begin
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      main_data_next = '0;
      skid_ctrl_next = '0;
      skid_data_next = '0;
    end

    in_ready_next  = (state_next != ST_FULL);
    out_valid_next = (state_next != ST_EMPTY);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
    end
  end

  // Per-bit mask so an idle boundary always presents a NOP control word
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign Out_Ctrl[gi] = main_ctrl_reg[gi] & out_valid_reg;
    end
  endgenerate

  assign In_Ready  = in_ready_reg;
  assign Out_Valid = out_valid_reg;
  assign Out_Data  = main_data_reg;
  assign Occupancy = occ_count(state_reg);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Out_Ready & ~out_valid_reg),
    .Count  (Bubble_Count)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and random check of pipe_stage_elastic against a FIFO scoreboard.
module tb_pipe_stage_elastic;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 133;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_count;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .Flush        (flush),
    .In_Valid     (in_valid),
    .In_Ready     (in_ready),
    .In_Ctrl      (in_ctrl),
    .In_Data      (in_data),
    .Out_Valid    (out_valid),
    .Out_Ready    (out_ready),
    .Out_Ctrl     (out_ctrl),
    .Out_Data     (out_data),
    .Occupancy    (occupancy),
    .Bubble_Count (bubble_count)
  );

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t             sb[$];
  logic              m_ready  = 1'b0;
  logic [CNT_W-1:0]  m_bubble = '0;
  logic [DATA_W-1:0] m_data   = '0;
  int                total = 0;
  int                bad   = 0;
  bit                verbose = 1'b1;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the scoreboard model, then check outputs
  task automatic cycle(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy,
                       input logic fl, input logic rs);
    beat_t b;
    logic  m_push;
    logic  m_pop;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rs;
    if (!rs) begin
      sb.delete();
      m_ready  = 1'b0;
      m_bubble = '0;
      m_data   = '0;
    end else begin
      if (ordy && (sb.size() == 0) && (m_bubble != {CNT_W{1'b1}}))
        m_bubble = m_bubble + 1'b1;
      if (fl) begin
        sb.delete();
        m_data = '0;
      end else begin
        m_pop  = (sb.size() > 0) && ordy;
        m_push = v && m_ready;
        if (m_pop) begin
          b = sb.pop_front();
          if (verbose) $display("beat out ctrl=%0h data=%0h", b.c, b.d);
        end
        if (m_push) begin
          b.c = c;
          b.d = d;
          sb.push_back(b);
        end
      end
      m_ready = (sb.size() != 2);
      if (sb.size() > 0) m_data = sb[0].d;
    end
    @(posedge clk);
    #1;
    chk("out_valid", DATA_W'(out_valid), DATA_W'(sb.size() > 0));
    chk("out_ctrl", DATA_W'(out_ctrl), (sb.size() > 0) ? DATA_W'(sb[0].c) : '0);
    chk("out_data", out_data, m_data);
    chk("occupancy", DATA_W'(occupancy), DATA_W'(sb.size()));
    chk("in_ready", DATA_W'(in_ready), DATA_W'(m_ready));
    chk("bubble", DATA_W'(bubble_count), DATA_W'(m_bubble));
  endtask

  function automatic logic [CTRL_W-1:0] ctl(input int k);
    return 8'h40 | 8'(k & 15);
  endfunction

  initial begin
    logic [DATA_W-1:0] rd;
    logic [CNT_W-1:0]  exp_bub [5];
    exp_bub[0] = 2'd1; exp_bub[1] = 2'd2; exp_bub[2] = 2'd3;
    exp_bub[3] = 2'd3; exp_bub[4] = 2'd3;

    // Reset held with an upstream beat offered
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 133'h77, 1'b1, 1'b0, 1'b0);
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_ctrl", DATA_W'(out_ctrl), '0);
    chk("rst_occ", DATA_W'(occupancy), '0);
    chk("rst_in_ready", DATA_W'(in_ready), '0);
    chk("rst_bubble", DATA_W'(bubble_count), '0);

    // Release and idle with Out_Ready=1: bubble counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      if (i == 0) chk("rel_in_ready", DATA_W'(in_ready), DATA_W'(1));
      chk("bubble_seq", DATA_W'(bubble_count), DATA_W'(exp_bub[i]));
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("bubble_flush", DATA_W'(bubble_count), DATA_W'(3));
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("bubble_rst", DATA_W'(bubble_count), '0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Streaming 0x1..0x8 at full rate
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, ctl(k), DATA_W'(k), 1'b1, 1'b0, 1'b1);
      chk("stream_data", out_data, DATA_W'(k));
      chk("stream_occ", DATA_W'(occupancy), DATA_W'(1));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure: A, B fill the buffer, C waits upstream
    cycle(1'b1, ctl(10), 133'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, ctl(11), 133'hB, 1'b0, 1'b0, 1'b1);
    chk("bp_full", DATA_W'(occupancy), DATA_W'(2));
    chk("bp_in_ready", DATA_W'(in_ready), '0);
    cycle(1'b1, ctl(12), 133'hC, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, ctl(12), 133'hC, 1'b0, 1'b0, 1'b1);
    chk("bp_head", out_data, 133'hA);
    cycle(1'b1, ctl(12), 133'hC, 1'b1, 1'b0, 1'b1);
    chk("bp_second", out_data, 133'hB);
    cycle(1'b1, ctl(12), 133'hC, 1'b1, 1'b0, 1'b1);
    chk("bp_third", out_data, 133'hC);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Flush while full with 0xD offered
    cycle(1'b1, ctl(14), 133'hE, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, ctl(15), 133'hF, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, ctl(13), 133'hD, 1'b1, 1'b1, 1'b1);
    chk("fl_occ", DATA_W'(occupancy), '0);
    chk("fl_out_valid", DATA_W'(out_valid), '0);
    chk("fl_out_ctrl", DATA_W'(out_ctrl), '0);
    chk("fl_in_ready", DATA_W'(in_ready), DATA_W'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("fl_no_d", DATA_W'(out_valid && (out_data == 133'hD)), '0);
    end

    // Random push/pop/flush against the scoreboard
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), 8'($urandom), rd,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
